// File: rtl/mlp_int8_pkg.sv
// Shared int8 requantization constants and arithmetic helpers.
// Arithmetic is carried in ACC_W = IPREC_DEF+1 bits so the rounding add cannot wrap.
package mlp_int8_pkg;

    localparam int IPREC_DEF = 32;
    localparam int OPREC_DEF = 8;
    localparam int SHW_DEF   = 5;
    localparam int ACC_W     = IPREC_DEF + 1;
    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Round-half-up arithmetic right shift: (value + 2^(shift-1)) >>> shift.
    function automatic acc_t round_shift(input acc_t value, input logic [SHW_DEF-1:0] shift);
        acc_t rnd;
        rnd = (shift == '0) ? '0 : (acc_t'(1) <<< (shift - SHW_DEF'(1)));
        return (value + rnd) >>> shift;
    endfunction

    function automatic acc_t sat_signed(input acc_t value, input int width);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
        lo = -hi - acc_t'(1);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/requant_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after the write.
// A push while full is ignored unless a pop happens in the same cycle.
module requant_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // At full, push+pop writes the slot being vacated; the head was already consumed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/requant_relu.sv
// Requantize 32-bit reduced results to int8 (round shift, ReLU, saturate), 3-cycle latency to FIFO head.
// No input backpressure: upstream pauses on o_almost_full; drops when full set sticky o_overflow.
module requant_relu
    import mlp_int8_pkg::*;
#(
    parameter int IPREC      = IPREC_DEF,
    parameter int OPREC      = OPREC_DEF,
    parameter int SHW        = SHW_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IPREC-1:0] i_data,
    input  logic [SHW-1:0]   i_shift,
    input  logic             i_relu,
    output logic             o_almost_full,
    output logic             o_overflow,
    output logic             o_valid,
    output logic [OPREC-1:0] o_data,
    input  logic             i_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             s1_vld_q, s1_vld_d;
    acc_t             s1_t_q, s1_t_d;
    logic             s2_vld_q, s2_vld_d;
    logic [OPREC-1:0] s2_dat_q, s2_dat_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;

    acc_t             relu_t;
    logic [CW:0]      occupancy;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    assign o_valid       = ~empty;
    assign pop           = o_valid & i_ready;
    assign o_almost_full = af_q;
    assign o_overflow    = ovf_q;

    always_comb begin
        s1_vld_d  = i_valid;
        s1_t_d    = round_shift(acc_t'({i_data[IPREC-1], i_data}), i_shift);
        relu_t    = (i_relu && (s1_t_q < 0)) ? '0 : s1_t_q;
        s2_vld_d  = s1_vld_q;
        s2_dat_d  = OPREC'(sat_signed(relu_t, OPREC));
        // Elements already committed: buffered plus both pipeline stages.
        occupancy = (CW+1)'(count) + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);
        af_d      = (occupancy >= (CW+1)'(FIFO_DEPTH - AF_MARGIN));
        ovf_d     = ovf_q | (s2_vld_q & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_t_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_t_q   <= s1_t_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    requant_fifo #(
        .W     (OPREC),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (s2_vld_q),
        .push_dat_i (s2_dat_q),
        .pop_i      (pop),
        .head_dat_o (o_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

endmodule

// File: tb/tb_requant_relu.sv
// Directed bench for requant_relu: rounding, saturation, ReLU, backpressure, overflow, reset.
module tb_requant_relu;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic [4:0]  i_shift;
    logic        i_relu;
    logic        o_almost_full;
    logic        o_overflow;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready;

    int checks = 0;
    int errors = 0;

    requant_relu dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_shift       (i_shift),
        .i_relu        (i_relu),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_almost_full !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h af=%b ovf=%b expected 0 00 0 0",
                     o_valid, o_data, o_almost_full, o_overflow);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_rounding;
        int din[4];
        int ex[4];
        din = '{300, 6, -6, -7};
        ex  = '{75, 2, -1, -2};
        i_shift = 5'd2;
        i_relu  = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (c >= 3 && c < 7) begin
                if (o_valid !== 1'b1 || o_data !== 8'(ex[c-3])) begin
                    errors++;
                    $display("FAIL round[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                             c - 3, o_valid, $signed(o_data), ex[c-3]);
                end
            end else if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL round_idle cycle %0d: valid=%b expected 0", c, o_valid);
            end
            i_valid = 1'b0;
            i_data  = '0;
            if (c < 4) begin
                i_valid = 1'b1;
                i_data  = 32'(din[c]);
            end
            tick;
        end
    endtask

    task automatic test_saturation;
        int din[4];
        int ex[4];
        din = '{1000, -1000, 127, -128};
        ex  = '{127, -128, 127, -128};
        i_shift = 5'd0;
        i_relu  = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c >= 3 && c < 7) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== 8'(ex[c-3])) begin
                    errors++;
                    $display("FAIL sat[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                             c - 3, o_valid, $signed(o_data), ex[c-3]);
                end
            end
            i_valid = 1'b0;
            i_data  = '0;
            if (c < 4) begin
                i_valid = 1'b1;
                i_data  = 32'(din[c]);
            end
            tick;
        end
        // Largest positive input with the largest shift: rounding add must not wrap.
        i_shift = 5'd31;
        i_valid = 1'b1;
        i_data  = 32'h7FFF_FFFF;
        tick;
        i_valid = 1'b0;
        i_data  = '0;
        tick;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_shift31_latency: valid=%b expected 0 at cycle 2", o_valid);
        end
        tick;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd1) begin
            errors++;
            $display("FAIL sat_shift31: valid=%b data=%0d expected valid=1 data=1",
                     o_valid, $signed(o_data));
        end
        tick;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_shift31_pop: valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_relu;
        int din[3];
        int ex[3];
        din = '{-50, 0, 50};
        ex  = '{0, 0, 50};
        i_shift = 5'd0;
        i_relu  = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c >= 3 && c < 6) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== 8'(ex[c-3])) begin
                    errors++;
                    $display("FAIL relu[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                             c - 3, o_valid, $signed(o_data), ex[c-3]);
                end
            end
            i_valid = 1'b0;
            i_data  = '0;
            if (c < 3) begin
                i_valid = 1'b1;
                i_data  = 32'(din[c]);
            end
            tick;
        end
        i_relu  = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hFFFF_FFCE;
        tick;
        i_valid = 1'b0;
        i_data  = '0;
        tick;
        tick;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hCE) begin
            errors++;
            $display("FAIL relu_off: valid=%b data=%h expected valid=1 data=ce", o_valid, o_data);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int   issued;
        logic af_prev;
        issued  = 0;
        af_prev = 1'b0;
        i_shift = 5'd0;
        i_relu  = 1'b0;
        i_ready = 1'b0;
        for (int c = 0; c < 18; c++) begin
            checks++;
            if (o_almost_full !== (c >= 15)) begin
                errors++;
                $display("FAIL af cycle %0d: af=%b expected %b", c, o_almost_full, (c >= 15));
            end
            if (c == 5 || c == 10 || c == 17) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== 8'hEC) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: valid=%b data=%h expected valid=1 data=ec",
                             c, o_valid, o_data);
                end
            end
            i_valid = 1'b0;
            i_data  = '0;
            if (issued < 16 && !af_prev) begin
                i_valid = 1'b1;
                i_data  = 32'(issued * 3 - 20);
                issued++;
            end
            af_prev = o_almost_full;
            tick;
        end
        i_valid = 1'b0;
        checks++;
        if (issued != 16) begin
            errors++;
            $display("FAIL bp_issued: issued=%0d expected 16", issued);
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b expected 0", o_overflow);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'(k * 3 - 20)) begin
                errors++;
                $display("FAIL bp_drain[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                         k, o_valid, $signed(o_data), k * 3 - 20);
            end
            i_ready = 1'b1;
            tick;
        end
        tick;
        checks++;
        if (o_valid !== 1'b0 || o_almost_full !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b af=%b expected 0 0", o_valid, o_almost_full);
        end
    endtask

    task automatic test_overflow;
        i_shift = 5'd0;
        i_relu  = 1'b0;
        i_ready = 1'b0;
        for (int c = 0; c < 23; c++) begin
            if (c == 18 || c == 19) begin
                checks++;
                if (o_overflow !== (c == 19)) begin
                    errors++;
                    $display("FAIL ovf_edge cycle %0d: ovf=%b expected %b", c, o_overflow, (c == 19));
                end
            end
            i_valid = (c < 20);
            i_data  = 32'(c + 1);
            tick;
        end
        i_valid = 1'b1;
        i_data  = 32'd99;
        tick;
        i_valid = 1'b0;
        i_data  = '0;
        tick;
        // 99 sits in stage 2 now: pop the head in the same cycle it is pushed.
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd1) begin
            errors++;
            $display("FAIL ovf_head: valid=%b data=%0d expected valid=1 data=1", o_valid, o_data);
        end
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
        tick;
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", o_overflow);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== ((k < 15) ? 8'(k + 2) : 8'd99)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                         k, o_valid, o_data, (k < 15) ? k + 2 : 99);
            end
            i_ready = 1'b1;
            tick;
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_midstream;
        i_shift = 5'd0;
        i_relu  = 1'b0;
        i_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            i_valid = 1'b1;
            i_data  = 32'(c + 40);
            tick;
        end
        i_valid = 1'b0;
        i_data  = '0;
        checks++;
        if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid=%b ovf=%b expected 1 1", o_valid, o_overflow);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_almost_full !== 1'b0 || o_overflow !== 1'b0 || o_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid: valid=%b af=%b ovf=%b data=%h expected 0 0 0 00",
                     o_valid, o_almost_full, o_overflow, o_data);
        end
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale cycle %0d: valid=%b data=%h expected valid=0", c, o_valid, o_data);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_shift = '0;
        i_relu  = 1'b0;
        i_ready = 1'b0;
        test_reset;
        test_rounding;
        test_saturation;
        test_relu;
        test_backpressure;
        test_overflow;
        test_reset_midstream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/requant_relu.md
Name: requant_relu

Overview:
- Sits directly downstream of the per-layer reduction stage.
- Takes that stage's 32-bit accumulated/reduced results and requantizes them to int8: rounding arithmetic right shift, optional ReLU, signed saturation.
- Buffers the int8 results in an output FIFO with ready/valid toward the next MVM layer or NoC interface.
- The reduction stage has no backpressure, so this block exports an almost-full flag that upstream uses to pause issue.

Parameters:
IPREC, 32, width of signed input element (reduced accumulator)
OPREC, 8, width of signed output element
SHW, 5, width of shift-amount config field
FIFO_DEPTH, 16, output FIFO entries (power of two, >= 4)
AF_MARGIN, 2, extra free entries kept in reserve for upstream reaction lag

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_valid  input  1  input element valid (no ready; always accepted)
i_data  input  IPREC  signed reduced result
i_shift  input  SHW  right-shift amount; quasi-static, changed only while block idle
i_relu  input  1  1 = apply ReLU; quasi-static
o_almost_full  output  1  upstream must stop asserting i_valid starting the cycle after this is seen high
o_overflow  output  1  sticky: an element was dropped because FIFO was full
o_valid  output  1  FIFO head valid
o_data  output  OPREC  signed requantized element at FIFO head
i_ready  input  1  downstream accepts head when o_valid && i_ready

Behaviour:
- Reset (synchronous, rst high at posedge): pipeline valids=0, FIFO pointers/count=0, o_valid=0, o_data=0, o_almost_full=0, o_overflow=0. Reset mid-operation discards all in-flight and buffered data; no partial outputs after reset.
- Stage 1 (registered), with i_valid:
  - rnd = (i_shift==0) ? 0 : 1<<(i_shift-1)
  - t = (sext(i_data) + rnd) >>> i_shift
  - Computed in IPREC+1 bits so the add never wraps.
  - Round-half-up: -6>>2 with rounding gives -1; 6 gives 2.
- Stage 2 (registered):
  - If i_relu and t<0, then t=0.
  - Saturate to [-2^(OPREC-1), 2^(OPREC-1)-1], i.e. [-128, 127].
- Stage 2 output with valid is written into FIFO at the next posedge.
- Latency: i_valid at cycle N → o_valid high at cycle N+3 when FIFO was empty and i_ready ignored. Throughput 1 element/cycle.
- FIFO: first-word-fall-through. o_data = head entry whenever o_valid. o_data holds its value while o_valid && !i_ready.
- Pop when o_valid && i_ready. Push when stage 2 valid.
- Push and pop in same cycle: count unchanged, allowed even when full. Order preserved.
- Full with push and no pop: element dropped, FIFO unchanged, o_overflow set and held until rst.
- Empty: o_valid=0. i_ready ignored.
- o_almost_full registered: (count + stage1_valid + stage2_valid) >= FIFO_DEPTH - AF_MARGIN.
- Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- Changing i_shift/i_relu while data is in stages 1–2 is undefined. The bench only changes them when the pipeline is empty.

Decomposition:
- Shared package mlp_int8_pkg holds:
  - constants IPREC/OPREC defaults
  - INT8_MAX=127, INT8_MIN=-128
  - function sat_signed(value, width)
  - function round_shift(value, shift)
- Natural sub-module: requant_fifo (parameterized sync FWFT FIFO: data, push, pop, full, empty, count).
- Stages 1–2 and almost-full logic stay in requant_relu.

Test Plan:
- Rounding/shift: relu=0, shift=2, inputs 300, 6, -6, -7 → outputs 75, 2, -1, -2, appearing in order starting 3 cycles after first i_valid, with i_ready=1.
- Saturation: shift=0, relu=0, inputs 1000, -1000, 127, -128 → 127, -128, 127, -128. Then shift=31, input 0x7FFFFFFF → 1 (no wrap on rounding add).
- ReLU: relu=1, shift=0, inputs -50, 0, 50 → 0, 0, 50. relu=0, input -50 → 0xCE.
- Backpressure and almost-full: i_ready=0, stream 16 consecutive inputs while honouring o_almost_full → o_almost_full rises when count+inflight reaches 14. o_overflow stays 0. Then i_ready=1 drains all accepted values in order, o_data stable while stalled.
- Overflow: i_ready=0, ignore o_almost_full, push 20 elements → FIFO holds first 16, o_overflow=1 sticky. Simultaneous push+pop at full keeps count=16 without setting further drops.
- Reset mid-stream: assert rst for 1 cycle with 2 elements in pipeline and 5 in FIFO → next cycle o_valid=0, o_almost_full=0, o_overflow=0. No stale elements emerge afterwards.
